// File: rtl/exp_mu_mult_core.sv
// Arithmetic/control core for the S0*exp(t*mu) path generator: sweep-enable SR flop,
// pipelined frac(t*mu) multiplier and pipelined Q4.14 x Q4.14 -> Q3.15 scaler.
module exp_mu_mult_core #(
    parameter int LAT_TMU = 3,
    parameter int LAT_P   = 3
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iSet,
    input  logic        iClr,
    output logic        oQ,
    input  logic [8:0]  iT,
    input  logic [17:0] iMu,
    output logic [17:0] oTMu,
    input  logic [17:0] iA,
    input  logic [17:0] iB,
    output logic [17:0] oP
);

    logic        q_q, q_d;
    logic [8:0]  t_q;
    logic [17:0] mu_q;
    logic [17:0] a_q, b_q;
    logic [17:0] tmu_prod_d;
    logic [17:0] p_prod_d;
    logic [17:0] tmu_pipe_q [LAT_TMU];
    logic [17:0] p_pipe_q   [LAT_P];

    // Clear wins over set so a sweep-done pulse can never be masked by a restart.
    always_comb begin
        q_d = q_q;
        if (iClr) begin
            q_d = 1'b0;
        end else if (iSet) begin
            q_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    // Only the fractional 18 bits of t*mu are kept, so an 18-bit product suffices.
    assign tmu_prod_d = {9'b0, t_q} * mu_q;

    // Q8.28 product; bits [30:13] form Q3.15 with the top bits wrapping away.
    assign p_prod_d = 18'((31'(a_q) * 31'(b_q)) >> 13);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            t_q  <= '0;
            mu_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
        end else begin
            t_q  <= iT;
            mu_q <= iMu;
            a_q  <= iA;
            b_q  <= iB;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < LAT_TMU; i++) begin
                tmu_pipe_q[i] <= '0;
            end
        end else begin
            tmu_pipe_q[0] <= tmu_prod_d;
            for (int i = 1; i < LAT_TMU; i++) begin
                tmu_pipe_q[i] <= tmu_pipe_q[i-1];
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < LAT_P; i++) begin
                p_pipe_q[i] <= '0;
            end
        end else begin
            p_pipe_q[0] <= p_prod_d;
            for (int i = 1; i < LAT_P; i++) begin
                p_pipe_q[i] <= p_pipe_q[i-1];
            end
        end
    end

    assign oQ   = q_q;
    assign oTMu = tmu_pipe_q[LAT_TMU-1];
    assign oP   = p_pipe_q[LAT_P-1];

endmodule

// File: tb/tb_exp_mu_mult_core.sv
// Directed bench for exp_mu_mult_core: SR flop, both multipliers, latency, streaming, reset.
module tb_exp_mu_mult_core;

    logic        CLK;
    logic        RST;
    logic        iSet;
    logic        iClr;
    logic        oQ;
    logic [8:0]  iT;
    logic [17:0] iMu;
    logic [17:0] oTMu;
    logic [17:0] iA;
    logic [17:0] iB;
    logic [17:0] oP;

    int n_tests;
    int n_fail;

    exp_mu_mult_core #(.LAT_TMU(3), .LAT_P(3)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .iSet (iSet),
        .iClr (iClr),
        .oQ   (oQ),
        .iT   (iT),
        .iMu  (iMu),
        .oTMu (oTMu),
        .iA   (iA),
        .iB   (iB),
        .oP   (oP)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [17:0] obs, input logic [17:0] expv);
        n_tests++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s observed=%05h expected=%05h", tag, obs, expv);
        end
    endtask

    // Drive one operand set and hold it; outputs keep the previous results for three
    // falling edges and show the new ones on the fourth.
    task automatic vec(input string tag,
                       input logic [8:0] t, input logic [17:0] mu,
                       input logic [17:0] a, input logic [17:0] b,
                       input logic [17:0] exp_tmu, input logic [17:0] exp_p,
                       input logic [17:0] old_tmu, input logic [17:0] old_p);
        iT  = t;
        iMu = mu;
        iA  = a;
        iB  = b;
        for (int k = 1; k <= 3; k++) begin
            @(negedge CLK);
            chk({tag, "_tmu_hold"}, oTMu, old_tmu);
            chk({tag, "_p_hold"}, oP, old_p);
        end
        @(negedge CLK);
        chk({tag, "_tmu"}, oTMu, exp_tmu);
        chk({tag, "_p"}, oP, exp_p);
        $display("[TB] vec %s t=%0d mu=%05h a=%05h b=%05h -> tmu=%05h p=%05h",
                 tag, t, mu, a, b, oTMu, oP);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        RST  = 1'b1;
        iSet = 1'b0;
        iClr = 1'b0;
        iT   = '0;
        iMu  = '0;
        iA   = '0;
        iB   = '0;

        // Reset state
        repeat (2) @(negedge CLK);
        chk("rst_q", {17'b0, oQ}, 18'h0);
        chk("rst_tmu", oTMu, 18'h0);
        chk("rst_p", oP, 18'h0);
        RST = 1'b0;

        // SR flip-flop
        iSet = 1'b1;
        @(negedge CLK); chk("sr_set", {17'b0, oQ}, 18'h1);
        iSet = 1'b0;
        @(negedge CLK); chk("sr_hold1", {17'b0, oQ}, 18'h1);
        @(negedge CLK); chk("sr_hold2", {17'b0, oQ}, 18'h1);
        iClr = 1'b1;
        @(negedge CLK); chk("sr_clr", {17'b0, oQ}, 18'h0);
        iClr = 1'b0;
        iSet = 1'b1;
        @(negedge CLK); chk("sr_set2", {17'b0, oQ}, 18'h1);
        iClr = 1'b1;
        @(negedge CLK); chk("sr_both", {17'b0, oQ}, 18'h0);
        iSet = 1'b0;
        iClr = 1'b0;
        @(negedge CLK); chk("sr_idle", {17'b0, oQ}, 18'h0);
        $display("[TB] sr sequence done q=%0b", oQ);

        // Directed multiplier vectors, each checking exact latency against the previous result
        vec("v_quarter", 9'd3,   18'h10000, 18'h04000, 18'h04000, 18'h30000, 18'h08000, 18'h00000, 18'h00000);
        vec("v_wrap",    9'd511, 18'h3FFFF, 18'h08000, 18'h06000, 18'h3FE01, 18'h18000, 18'h30000, 18'h08000);
        vec("v_tzero",   9'd0,   18'h2ABCD, 18'h3FFFF, 18'h3FFFF, 18'h00000, 18'h3FFC0, 18'h3FE01, 18'h18000);
        vec("v_again",   9'd3,   18'h10000, 18'h04000, 18'h04000, 18'h30000, 18'h08000, 18'h00000, 18'h3FFC0);

        // Streaming: t ramp with mu=0x200, a ramp (multiples of 32) with b=1.5
        for (int cyc = 0; cyc < 516; cyc++) begin
            @(negedge CLK);
            if (cyc >= 4) begin
                chk("stream_tmu", oTMu, 18'(((cyc - 4) * 32'h200) & 32'h3FFFF));
                chk("stream_p", oP, 18'(3 * ((cyc - 4) * 32)));
                if (((cyc - 4) % 64) == 0 || cyc == 515) begin
                    $display("[TB] stream idx=%0d tmu=%05h p=%05h", cyc - 4, oTMu, oP);
                end
            end
            if (cyc < 512) begin
                iT  = 9'(cyc);
                iMu = 18'h00200;
                iA  = 18'(cyc * 32);
                iB  = 18'h06000;
            end
        end

        // Reset mid-stream with nonzero operands and oQ set
        iSet = 1'b1;
        iT   = 9'd5;
        iMu  = 18'h10000;
        iA   = 18'h04000;
        iB   = 18'h04000;
        @(negedge CLK);
        iSet = 1'b0;
        repeat (4) @(negedge CLK);
        chk("pre_rst_q", {17'b0, oQ}, 18'h1);
        chk("pre_rst_tmu", oTMu, 18'h10000);
        chk("pre_rst_p", oP, 18'h08000);
        #2 RST = 1'b1;
        #1;
        chk("async_rst_q", {17'b0, oQ}, 18'h0);
        chk("async_rst_tmu", oTMu, 18'h0);
        chk("async_rst_p", oP, 18'h0);
        @(negedge CLK);
        RST = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge CLK);
            chk("refill_tmu_zero", oTMu, 18'h0);
            chk("refill_p_zero", oP, 18'h0);
            chk("refill_q_zero", {17'b0, oQ}, 18'h0);
        end
        @(negedge CLK);
        chk("refill_tmu", oTMu, 18'h10000);
        chk("refill_p", oP, 18'h08000);
        $display("[TB] reset refill tmu=%05h p=%05h q=%0b", oTMu, oP, oQ);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
